// File: rtl/secded_load_pipe.sv
// secded_load_pipe: two-stage SEC-DED check/correct stage on the memory load path.
// Stage 1 computes the syndrome and overall parity; stage 2 classifies and corrects.
// Also keeps saturating SEC/DED counters and a first-error log.
// Optional build macro SECDED_ERR_INJECT_EN adds an inj_mask port that XORs the
// incoming {parity, data} word before checking, for fault injection.
module secded_load_pipe #(
    parameter int DATA_W = 32,
    parameter int CHK_W  = 6,
    parameter int PAR_W  = CHK_W + 1,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [PAR_W-1:0]        in_parity,
    input  logic                    special_load,
`ifdef SECDED_ERR_INJECT_EN
    input  logic [DATA_W+PAR_W-1:0] inj_mask,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [PAR_W-1:0]        out_parity,
    output logic                    single_error,
    output logic                    DED_exception,
    input  logic                    clr_counters,
    output logic [CNT_W-1:0]        sec_count,
    output logic [CNT_W-1:0]        ded_count,
    output logic                    err_log_valid,
    output logic [CHK_W-1:0]        err_log_syndrome,
    output logic                    err_log_ded
);

    localparam int LAST_POS = DATA_W + CHK_W;
    localparam logic [CHK_W:0] LAST_POS_V = (CHK_W + 1)'(LAST_POS);

    // Codeword position of data bit j: the j-th non-power-of-two position, starting at 3.
    function automatic int data_pos(input int j);
        int cnt;
        int result;
        cnt    = 0;
        result = 0;
        for (int p = 1; p <= LAST_POS; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == j) result = p;
                cnt++;
            end
        end
        return result;
    endfunction

    // Data bits covered by Hamming check bit i (those whose position has bit i set).
    function automatic logic [DATA_W-1:0] chk_mask(input int i);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int j = 0; j < DATA_W; j++) begin
            if (((data_pos(j) >> i) & 1) != 0) m = m | (DATA_W'(1) << j);
        end
        return m;
    endfunction

    // Pipeline state
    logic                s1_valid;
    logic [DATA_W-1:0]   s1_data;
    logic [PAR_W-1:0]    s1_parity;
    logic                s1_special;
    logic [CHK_W-1:0]    s1_syn;
    logic                s1_ovr;

    logic                s2_valid;
    logic [DATA_W-1:0]   s2_data;
    logic [PAR_W-1:0]    s2_parity;
    logic                s2_single;
    logic                s2_ded;
    logic                s2_special;
    logic [CHK_W-1:0]    s2_syn;

    logic                advance;
    logic [DATA_W-1:0]   raw_data;
    logic [PAR_W-1:0]    raw_parity;
    logic [CHK_W-1:0]    syn_calc;
    logic                ovr_calc;

    logic [DATA_W-1:0]   flip_data;
    logic [PAR_W-1:0]    flip_parity;
    logic                syn_nz;
    logic                in_range;
    logic                cls_single;
    logic                cls_ded;
    logic [DATA_W-1:0]   cls_data;
    logic [PAR_W-1:0]    cls_parity;

    logic                handshake;
    logic                sec_inc;
    logic                ded_inc;
    logic                log_capture;

    // Both stages move together whenever the output register is empty or being drained.
    assign advance  = !s2_valid || out_ready;
    assign in_ready = advance;

`ifdef SECDED_ERR_INJECT_EN
    assign {raw_parity, raw_data} = {in_parity, in_data} ^ inj_mask;
`else
    assign {raw_parity, raw_data} = {in_parity, in_data};
`endif

    // Syndrome: recomputed Hamming checks XOR the stored ones.
    for (genvar i = 0; i < CHK_W; i++) begin : g_syn
        localparam logic [DATA_W-1:0] CHK_MASK = chk_mask(i);
        assign syn_calc[i] = (^(raw_data & CHK_MASK)) ^ raw_parity[i];
    end

    // Overall parity across every stored bit; zero for an intact word.
    assign ovr_calc = ^{raw_data, raw_parity};

    // Stage 1 register: raw word plus its syndrome and overall parity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_parity  <= '0;
            s1_special <= 1'b0;
            s1_syn     <= '0;
            s1_ovr     <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data    <= raw_data;
                s1_parity  <= raw_parity;
                s1_special <= special_load;
                s1_syn     <= syn_calc;
                s1_ovr     <= ovr_calc;
            end
        end
    end

    // A flip is only applied when overall parity says a single bit went bad.
    for (genvar g = 0; g < DATA_W; g++) begin : g_flip_data
        localparam logic [CHK_W-1:0] POS = CHK_W'(data_pos(g));
        assign flip_data[g] = s1_ovr && (s1_syn == POS);
    end

    for (genvar i = 0; i < CHK_W; i++) begin : g_flip_chk
        localparam logic [CHK_W-1:0] CPOS = CHK_W'(1 << i);
        assign flip_parity[i] = s1_ovr && (s1_syn == CPOS);
    end

    assign flip_parity[PAR_W-1] = s1_ovr && !syn_nz;

    assign syn_nz   = |s1_syn;
    assign in_range = syn_nz && ({1'b0, s1_syn} <= LAST_POS_V);

    // Classification and correction; diagnostic loads pass raw and never raise DED.
    always_comb begin
        cls_single = s1_ovr && (!syn_nz || in_range);
        cls_ded    = syn_nz && !(s1_ovr && in_range) && !s1_special;
        cls_data   = s1_data;
        cls_parity = s1_parity;
        if (!s1_special) begin
            cls_data   = s1_data ^ flip_data;
            cls_parity = s1_parity ^ flip_parity;
        end
    end

    // Stage 2 register: the classified, corrected result presented on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_data    <= '0;
            s2_parity  <= '0;
            s2_single  <= 1'b0;
            s2_ded     <= 1'b0;
            s2_special <= 1'b0;
            s2_syn     <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data    <= cls_data;
                s2_parity  <= cls_parity;
                s2_single  <= cls_single;
                s2_ded     <= cls_ded;
                s2_special <= s1_special;
                s2_syn     <= s1_syn;
            end
        end
    end

    assign out_valid     = s2_valid;
    assign out_data      = s2_data;
    assign out_parity    = s2_parity;
    assign single_error  = s2_single;
    assign DED_exception = s2_ded;

    assign handshake   = s2_valid && out_ready;
    assign sec_inc     = handshake && s2_single && !s2_special;
    assign ded_inc     = handshake && s2_ded;
    assign log_capture = handshake && (s2_single || s2_ded) && !s2_special && !err_log_valid;

    // Saturating event counters and first-error log; a clear wins over any same-cycle update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_count        <= '0;
            ded_count        <= '0;
            err_log_valid    <= 1'b0;
            err_log_syndrome <= '0;
            err_log_ded      <= 1'b0;
        end else if (clr_counters) begin
            sec_count        <= '0;
            ded_count        <= '0;
            err_log_valid    <= 1'b0;
            err_log_syndrome <= '0;
            err_log_ded      <= 1'b0;
        end else begin
            if (sec_inc && (sec_count != '1)) sec_count <= sec_count + 1'b1;
            if (ded_inc && (ded_count != '1)) ded_count <= ded_count + 1'b1;
            if (log_capture) begin
                err_log_valid    <= 1'b1;
                err_log_syndrome <= s2_syn;
                err_log_ded      <= s2_ded;
            end
        end
    end

endmodule

// File: tb/tb_secded_load_pipe.sv
// tb_secded_load_pipe: directed self-checking bench for secded_load_pipe.
// A second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_secded_load_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [6:0]  in_parity;
    logic        special_load;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [6:0]  out_parity;
    logic        single_error;
    logic        ded_exception;
    logic        clr_counters;
    logic [15:0] sec_count;
    logic [15:0] ded_count;
    logic        err_log_valid;
    logic [5:0]  err_log_syndrome;
    logic        err_log_ded;

    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_data2;
    logic [6:0]  out_parity2;
    logic        single_error2;
    logic        ded_exception2;
    logic [1:0]  sec_count2;
    logic [1:0]  ded_count2;
    logic        err_log_valid2;
    logic [5:0]  err_log_syndrome2;
    logic        err_log_ded2;

    int passes = 0;
    int total  = 0;

    logic [31:0] s_data   [8];
    logic [6:0]  s_parity [8];
    logic [31:0] e_data   [8];
    logic [6:0]  e_parity [8];
    logic        e_single [8];

    secded_load_pipe #(.DATA_W(32), .CHK_W(6), .PAR_W(7), .CNT_W(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_parity        (in_parity),
        .special_load     (special_load),
`ifdef SECDED_ERR_INJECT_EN
        .inj_mask         ('0),
`endif
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_parity       (out_parity),
        .single_error     (single_error),
        .DED_exception    (ded_exception),
        .clr_counters     (clr_counters),
        .sec_count        (sec_count),
        .ded_count        (ded_count),
        .err_log_valid    (err_log_valid),
        .err_log_syndrome (err_log_syndrome),
        .err_log_ded      (err_log_ded)
    );

    secded_load_pipe #(.DATA_W(32), .CHK_W(6), .PAR_W(7), .CNT_W(2)) dut_sat (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready2),
        .in_data          (in_data),
        .in_parity        (in_parity),
        .special_load     (special_load),
`ifdef SECDED_ERR_INJECT_EN
        .inj_mask         ('0),
`endif
        .out_valid        (out_valid2),
        .out_ready        (out_ready),
        .out_data         (out_data2),
        .out_parity       (out_parity2),
        .single_error     (single_error2),
        .DED_exception    (ded_exception2),
        .clr_counters     (clr_counters),
        .sec_count        (sec_count2),
        .ded_count        (ded_count2),
        .err_log_valid    (err_log_valid2),
        .err_log_syndrome (err_log_syndrome2),
        .err_log_ded      (err_log_ded2)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) begin
            passes++;
        end else begin
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one word for a single cycle and return at the negedge where its result is visible.
    task automatic apply_stimulus(input logic [31:0] d, input logic [6:0] p, input logic sp);
        @(negedge clk);
        in_data      = d;
        in_parity    = p;
        special_load = sp;
        in_valid     = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] d, input logic [6:0] p,
                                input logic se, input logic ded);
        check({tag, "_valid"},  out_valid,     1'b1);
        check({tag, "_data"},   out_data,      d);
        check({tag, "_parity"}, out_parity,    p);
        check({tag, "_single"}, single_error,  se);
        check({tag, "_ded"},    ded_exception, ded);
    endtask

    initial begin
        logic [31:0] held_data;
        logic [6:0]  held_parity;
        int tx;
        int rx;

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_parity    = '0;
        special_load = 1'b0;
        out_ready    = 1'b1;
        clr_counters = 1'b0;
        held_data    = '0;
        held_parity  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready",  in_ready,      1'b1);
        check("rst_out_valid", out_valid,     1'b0);
        check("rst_out_data",  out_data,      32'h0);
        check("rst_sec",       sec_count,     16'd0);
        check("rst_ded",       ded_count,     16'd0);
        check("rst_log_valid", err_log_valid, 1'b0);
        rst_n = 1'b1;

        // Clean zero word, with a latency probe after one cycle
        @(negedge clk);
        in_data = 32'h0; in_parity = 7'b0000000; special_load = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("lat1_out_valid", out_valid, 1'b0);
        @(negedge clk);
        check_output("zero", 32'h0, 7'b0000000, 1'b0, 1'b0);
        @(negedge clk);
        check("zero_sec", sec_count, 16'd0);
        check("zero_ded", ded_count, 16'd0);

        // Single error on data[1] (position 5)
        apply_stimulus(32'h0000_0002, 7'b0000000, 1'b0);
        check_output("sec_d1", 32'h0, 7'b0000000, 1'b1, 1'b0);
        @(negedge clk);
        check("sec_d1_count",   sec_count,        16'd1);
        check("sec_d1_sat",     sec_count2,       2'd1);
        check("log_valid",      err_log_valid,    1'b1);
        check("log_syndrome",   err_log_syndrome, 6'd5);
        check("log_ded",        err_log_ded,      1'b0);

        // Single error on data[2] with a nonzero stored parity
        apply_stimulus(32'h0000_0006, 7'b1000101, 1'b0);
        check_output("sec_d2", 32'h2, 7'b1000101, 1'b1, 1'b0);

        // Single error on check bit 0
        apply_stimulus(32'h0000_0001, 7'b1000010, 1'b0);
        check_output("sec_c0", 32'h1, 7'b1000011, 1'b1, 1'b0);
        @(negedge clk);
        check("sec_c0_count", sec_count, 16'd3);

        // Double error
        apply_stimulus(32'h0000_0003, 7'b0000000, 1'b0);
        check_output("ded", 32'h3, 7'b0000000, 1'b0, 1'b1);
        @(negedge clk);
        check("ded_count",      ded_count,        16'd1);
        check("ded_log_hold",   err_log_syndrome, 6'd5);

        // Same double error as a diagnostic load
        apply_stimulus(32'h0000_0003, 7'b0000000, 1'b1);
        check_output("spec_ded", 32'h3, 7'b0000000, 1'b0, 1'b0);
        @(negedge clk);
        check("spec_ded_count", ded_count, 16'd1);

        // Single error as a diagnostic load: raw data, flag reported, not counted
        apply_stimulus(32'h0000_0002, 7'b0000000, 1'b1);
        check_output("spec_sec", 32'h2, 7'b0000000, 1'b1, 1'b0);
        @(negedge clk);
        check("spec_sec_count", sec_count, 16'd3);

        // Single error on the overall parity bit
        apply_stimulus(32'h0, 7'b1000000, 1'b0);
        check_output("sec_ovr", 32'h0, 7'b0000000, 1'b1, 1'b0);

        // Single error at the last position (data[31], position 38)
        apply_stimulus(32'h8000_0000, 7'b0000000, 1'b0);
        check_output("sec_last", 32'h0, 7'b0000000, 1'b1, 1'b0);
        @(negedge clk);
        check("sec_five",     sec_count,  16'd5);
        check("sec_sat_five", sec_count2, 2'd3);

        // Odd overall parity with syndrome 39 and 63: beyond the codeword
        apply_stimulus(32'h0, 7'b1100111, 1'b0);
        check_output("ded_s39", 32'h0, 7'b1100111, 1'b0, 1'b1);
        apply_stimulus(32'h0, 7'b1111111, 1'b0);
        check_output("ded_s63", 32'h0, 7'b1111111, 1'b0, 1'b1);
        @(negedge clk);
        check("ded_three",     ded_count,  16'd3);
        check("ded_sat_three", ded_count2, 2'd3);

        // Stream of 8 words with a 3-cycle output stall
        s_data[0] = 32'h1;         s_parity[0] = 7'b1000011; e_data[0] = 32'h1;         e_parity[0] = 7'b1000011; e_single[0] = 1'b0;
        s_data[1] = 32'h2;         s_parity[1] = 7'b1000101; e_data[1] = 32'h2;         e_parity[1] = 7'b1000101; e_single[1] = 1'b0;
        s_data[2] = 32'h4;         s_parity[2] = 7'b1000110; e_data[2] = 32'h4;         e_parity[2] = 7'b1000110; e_single[2] = 1'b0;
        s_data[3] = 32'h6;         s_parity[3] = 7'b0000011; e_data[3] = 32'h6;         e_parity[3] = 7'b0000011; e_single[3] = 1'b0;
        s_data[4] = 32'h8;         s_parity[4] = 7'b0000111; e_data[4] = 32'h8;         e_parity[4] = 7'b0000111; e_single[4] = 1'b0;
        s_data[5] = 32'hF;         s_parity[5] = 7'b1000111; e_data[5] = 32'hF;         e_parity[5] = 7'b1000111; e_single[5] = 1'b0;
        s_data[6] = 32'h8000_0000; s_parity[6] = 7'b0100110; e_data[6] = 32'h8000_0000; e_parity[6] = 7'b0100110; e_single[6] = 1'b0;
        s_data[7] = 32'h5;         s_parity[7] = 7'b1000110; e_data[7] = 32'h4;         e_parity[7] = 7'b1000110; e_single[7] = 1'b1;
        tx = 0;
        rx = 0;
        for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 6);
            #1;
            if (!out_ready) begin
                check("stall_in_ready",  in_ready,  1'b0);
                check("stall_out_valid", out_valid, 1'b1);
                if (cyc == 4) begin
                    held_data   = out_data;
                    held_parity = out_parity;
                end else begin
                    check("stall_hold_data",   out_data,   held_data);
                    check("stall_hold_parity", out_parity, held_parity);
                end
            end else if (out_valid) begin
                check("stream_data",   out_data,     e_data[rx]);
                check("stream_parity", out_parity,   e_parity[rx]);
                check("stream_single", single_error, e_single[rx]);
                rx++;
            end
            if (tx < 8) begin
                in_valid     = 1'b1;
                in_data      = s_data[tx];
                in_parity    = s_parity[tx];
                special_load = 1'b0;
                if (in_ready) tx++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", rx, 8);
        repeat (2) @(negedge clk);
        check("stream_no_dup", out_valid, 1'b0);
        check("stream_sec",    sec_count, 16'd6);

        // Reset with two words in flight
        @(negedge clk);
        in_data = 32'h1; in_parity = 7'b1000011; in_valid = 1'b1;
        @(negedge clk);
        in_data = 32'h2; in_parity = 7'b1000101;
        @(negedge clk);
        in_valid = 1'b0;
        check("flight_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_drop_valid", out_valid, 1'b0);
        check("rst_drop_sec",   sec_count, 16'd0);

        // Log a double error, then clear on the cycle a single error hands off
        apply_stimulus(32'h0000_0003, 7'b0000000, 1'b0);
        @(negedge clk);
        check("log2_ded",       err_log_ded,      1'b1);
        check("log2_syndrome",  err_log_syndrome, 6'd6);
        apply_stimulus(32'h0000_0002, 7'b0000000, 1'b0);
        check("clr_pre_single", single_error, 1'b1);
        clr_counters = 1'b1;
        @(negedge clk);
        clr_counters = 1'b0;
        check("clr_sec",       sec_count,     16'd0);
        check("clr_ded",       ded_count,     16'd0);
        check("clr_sec_sat",   sec_count2,    2'd0);
        check("clr_log_valid", err_log_valid, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/secded_load_pipe.md
Name: secded_load_pipe

Overview:
- Parametrised, pipelined SEC-DED check/correct stage on the memory load path.
- Successor to the combinational load ECC decoder: generic data width, valid/ready flow control, 2-cycle latency.
- Adds saturating SEC/DED event counters and a first-error capture log.
- Sits between the data-memory read port and load writeback.

Parameters:
- DATA_W, 32, data bits per word (>= 4).
- CHK_W, 6, Hamming check bits r; smallest r with 2^r >= DATA_W + r + 1.
- PAR_W, CHK_W+1, total stored parity bits.
- CNT_W, 16, width of each error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  load word presented.
- in_ready  out  1  stage 1 can accept.
- in_data  in  DATA_W  raw data read from memory.
- in_parity  in  PAR_W  raw stored parity.
- special_load  in  1  diagnostic raw load; sampled with in_data.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_W  corrected data.
- out_parity  out  PAR_W  corrected parity.
- single_error  out  1  single-bit error detected for this result.
- DED_exception  out  1  uncorrectable error for this result.
- clr_counters  in  1  synchronous clear of counters and log.
- sec_count  out  CNT_W  count of single errors accepted.
- ded_count  out  CNT_W  count of double errors accepted.
- err_log_valid  out  1  error log holds an entry.
- err_log_syndrome  out  CHK_W  syndrome of the logged error.
- err_log_ded  out  1  logged error was a double error.

Behaviour:
- Code:
  - Codeword positions 1..DATA_W+CHK_W.
  - Check bit i sits at position 2^i.
  - Data bits fill the remaining positions in ascending order, data[0] at position 3.
  - parity[CHK_W-1:0] are the Hamming checks.
  - parity[PAR_W-1] is even overall parity over all data bits and parity[CHK_W-1:0].
- Pipeline:
  - advance = !s2_valid || out_ready; in_ready = advance.
  - Stage 1 registers in_data, in_parity, special_load, syndrome s (recomputed checks XOR stored) and overall parity o.
  - Stage 2 registers the classified, corrected result.
  - Latency is 2 cycles with no stall; throughput is 1 per cycle.
  - When advance=0 both stages hold and outputs stay stable.
- Classification:
  - s=0, o=0: no error; data and parity pass unchanged.
  - o=1, s=0: single_error=1; flip parity[PAR_W-1].
  - o=1, 1 <= s <= DATA_W+CHK_W: single_error=1; flip the bit at position s (data or check bit).
  - o=1, s beyond the last position: DED_exception=1; no correction.
  - o=0, s!=0: DED_exception=1; data and parity pass uncorrected.
  - single_error and DED_exception are never both 1.
- special_load=1:
  - out_data and out_parity equal the raw inputs.
  - single_error is reported per the rules above; DED_exception is forced to 0.
  - Counters and log are not updated.
- Counters:
  - Increment on the out_valid && out_ready handshake when the corresponding flag is 1.
  - Saturate at all-ones.
  - clr_counters has priority over a same-cycle increment; the result is 0.
- Error log:
  - Captures syndrome and ded flag of the first flagged result on handshake, then sets err_log_valid.
  - Holds until clr_counters.
  - A same-cycle clear and capture leaves the log cleared.
- Reset:
  - Asynchronous; clears stage valids, out_valid, out_data, out_parity, flags, counters and log to 0.
  - in_ready is 1 after reset.
  - A word in flight at reset is dropped.

Optional Feature:
- Macro: SECDED_ERR_INJECT_EN.
- When defined:
  - Adds input port inj_mask [DATA_W+PAR_W-1:0].
  - {in_parity, in_data} is XORed with inj_mask before the syndrome is computed, and the XORed value is what stage 1 stores.
  - This supports bench fault injection.
- When undefined: the port is absent and the datapath is unchanged.

Test Plan:
- Reset, then data=0x0000_0000, parity=7'b0000000 -> out after 2 cycles: data 0x0, parity 0, no flags, counters 0.
- data=0x0000_0002, parity=7'b0000000 -> single_error=1, out_data=0x0, sec_count=1, err_log_syndrome=5, err_log_ded=0.
- data=0x0000_0006, parity=7'b1000101 -> single_error=1, out_data=0x2, out_parity=7'b1000101. Also data=0x1, parity=7'b1000010 -> out_parity=7'b1000011, out_data=0x1.
- data=0x0000_0003, parity=7'b0000000 -> DED_exception=1, out_data=0x3, ded_count=1. Repeat the same word with special_load=1 -> DED_exception=0, counters unchanged.
- Stream 8 words, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 while stalled, outputs stable, no loss or duplication; with CNT_W=2, 5 single errors -> sec_count=3.
- Assert rst_n low with 2 words in flight -> out_valid=0 immediately; no output after release. clr_counters on the same cycle as an error handshake -> counters 0, err_log_valid=0.
